// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiply controller.
// Op codes, FSM states, partial-product tags and datapath widths.
package mul_seq_pkg;

    localparam int XLEN = 32;
    localparam int HLEN = 16;
    localparam int ALEN = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SH0  = 2'd0,
        SH16 = 2'd1,
        SH32 = 2'd2
    } tag_e;

    // Bit offset at which a tagged partial product lands in the accumulator.
    function automatic logic [5:0] tag_shift(input tag_e t);
        logic [5:0] s;
        unique case (t)
            SH0:     s = 6'd0;
            SH16:    s = 6'd16;
            SH32:    s = 6'd32;
            default: s = 6'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_mul16.sv
// 16x16 unsigned multiplier with MULT_PIPE register stages.
// A valid bit and a shift tag ride alongside each product.
module mul16_pipe
    import mul_seq_pkg::*;
#(
    parameter int MULT_PIPE = 1
) (
    input  logic            clk,
    input  logic            clr_i,
    input  logic            in_valid_i,
    input  tag_e            in_tag_i,
    input  logic [HLEN-1:0] a_i,
    input  logic [HLEN-1:0] b_i,
    output logic            out_valid_o,
    output tag_e            out_tag_o,
    output logic [XLEN-1:0] out_prod_o
);

    logic [MULT_PIPE-1:0] vld_q;
    tag_e                 tag_q  [MULT_PIPE];
    logic [XLEN-1:0]      prod_q [MULT_PIPE];

    // Stage 0 captures the product; later stages shift it along; clear kills valids.
    always_ff @(posedge clk) begin
        vld_q[0]  <= in_valid_i & ~clr_i;
        tag_q[0]  <= in_tag_i;
        prod_q[0] <= {{HLEN{1'b0}}, a_i} * {{HLEN{1'b0}}, b_i};
        for (int i = 1; i < MULT_PIPE; i++) begin
            vld_q[i]  <= vld_q[i-1] & ~clr_i;
            tag_q[i]  <= tag_q[i-1];
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign out_valid_o = vld_q[MULT_PIPE-1];
    assign out_tag_o   = tag_q[MULT_PIPE-1];
    assign out_prod_o  = prod_q[MULT_PIPE-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 multiplier: four 16x16 partial products through one
// shared pipelined multiplier, 64-bit accumulate, signed high-word fix-up.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int MULT_PIPE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [ALEN-1:0] acc_q, acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] resp_q, resp_d;
    logic            rdy_q;

    logic            kill;
    logic            pclr;
    logic            pv;
    tag_e            ptag;
    logic [HLEN-1:0] pa, pb;
    logic            ov;
    tag_e            otag;
    logic [XLEN-1:0] oprod;

    logic [1:0]      last_issue;
    logic [XLEN-1:0] corr_a, corr_b, hi_fix;

    // Shared multiplier; cleared on reset or when an in-flight op is aborted.
    mul16_pipe #(
        .MULT_PIPE (MULT_PIPE)
    ) u_mul (
        .clk         (clk),
        .clr_i       (pclr),
        .in_valid_i  (pv),
        .in_tag_i    (ptag),
        .a_i         (pa),
        .b_i         (pb),
        .out_valid_o (ov),
        .out_tag_o   (otag),
        .out_prod_o  (oprod)
    );

    assign pclr = reset | kill;

    // MUL skips ah*bh since it only reaches the upper word.
    assign last_issue = (op_q == OP_MUL) ? 2'd2 : 2'd3;

    // Signed fix-up of the unsigned high word, modulo 2^32.
    always_comb begin
        corr_a = '0;
        corr_b = '0;
        if (a_q[XLEN-1] && (op_q == OP_MULXSU || op_q == OP_MULXSS))
            corr_a = b_q;
        if (b_q[XLEN-1] && op_q == OP_MULXSS)
            corr_b = a_q;
        hi_fix = acc_q[ALEN-1:XLEN] - corr_a - corr_b;
    end

    // Next-state, issue selection, accumulation and abort handling.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        kill    = 1'b0;
        pv      = 1'b0;
        ptag    = SH0;
        pa      = a_q[HLEN-1:0];
        pb      = b_q[HLEN-1:0];

        if (ov)
            acc_d = acc_q + (ALEN'(oprod) << tag_shift(otag));

        unique case (state_q)
            IDLE: begin
                if (req_valid && rdy_q) begin
                    state_d = ISSUE;
                    op_d    = op_e'(req_op);
                    a_d     = req_a;
                    b_d     = req_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                pv = 1'b1;
                unique case (cnt_q)
                    2'd0: begin
                        pa   = a_q[HLEN-1:0];
                        pb   = b_q[HLEN-1:0];
                        ptag = SH0;
                    end
                    2'd1: begin
                        pa   = a_q[HLEN-1:0];
                        pb   = b_q[XLEN-1:HLEN];
                        ptag = SH16;
                    end
                    2'd2: begin
                        pa   = a_q[XLEN-1:HLEN];
                        pb   = b_q[HLEN-1:0];
                        ptag = SH16;
                    end
                    default: begin
                        pa   = a_q[XLEN-1:HLEN];
                        pb   = b_q[XLEN-1:HLEN];
                        ptag = SH32;
                    end
                endcase
                if (cnt_q == last_issue) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == 2'(MULT_PIPE)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            FIX: begin
                state_d = DONE;
                acc_d   = {hi_fix, acc_q[XLEN-1:0]};
                resp_d  = (op_q == OP_MUL) ? acc_q[XLEN-1:0] : hi_fix;
            end
            DONE: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            if (state_q == ISSUE || state_q == DRAIN || state_q == FIX) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                kill    = 1'b1;
            end else if (state_q == DONE) begin
                state_d = IDLE;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            rdy_q   <= (state_d == IDLE);
        end
    end

    assign req_ready  = rdy_q;
    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench: two instances (MULT_PIPE 1 and 3) driven from shared
// inputs, table vectors, random ops vs. an arithmetic model, corner sequences.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      = 1'b1;
    logic        flush      = 1'b0;
    logic        resp_ready = 1'b0;
    logic [1:0]  req_op     = 2'b00;
    logic [31:0] req_a      = '0;
    logic [31:0] req_b      = '0;
    logic        rv0        = 1'b0;
    logic        rv1        = 1'b0;
    logic        sel        = 1'b0;

    logic        rq0, rq1, vv0, vv1, bz0, bz1;
    logic [31:0] d0, d1;

    logic        req_ready, resp_valid, busy;
    logic [31:0] resp_data;
    assign req_ready  = sel ? rq1 : rq0;
    assign resp_valid = sel ? vv1 : vv0;
    assign busy       = sel ? bz1 : bz0;
    assign resp_data  = sel ? d1  : d0;

    mul_seq_ctrl #(.MULT_PIPE(1)) u_p1 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rq0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .resp_valid(vv0), .resp_ready(resp_ready), .resp_data(d0), .busy(bz0)
    );

    mul_seq_ctrl #(.MULT_PIPE(3)) u_p3 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rq1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .resp_valid(vv1), .resp_ready(resp_ready), .resp_data(d1), .busy(bz1)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: true signed/unsigned 64-bit product, pick the word.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        if (op == 2'b10 || op == 2'b11) sa = longint'(signed'(a));
        else sa = longint'({32'b0, a});
        if (op == 2'b11) sb = longint'(signed'(b));
        else sb = longint'({32'b0, b});
        p = 64'(sa * sb);
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic d);
        return ((op == 2'b00) ? 3 : 4) + (d ? 3 : 1) + 2;
    endfunction

    task automatic set_rv(input logic d, input logic v);
        if (d) rv1 = v;
        else rv0 = v;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) check("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    // Accept one op and wait for resp_valid; response is left pending.
    task automatic do_op(input logic d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] data,
                         output int lat, output logic bz_ok);
        sel = d;
        wait_ready();
        req_op = op;
        req_a  = a;
        req_b  = b;
        set_rv(d, 1'b1);
        step();
        set_rv(d, 1'b0);
        lat   = 0;
        bz_ok = busy;
        while (!resp_valid && lat < 60) begin
            step();
            lat++;
            if (!busy) bz_ok = 1'b0;
        end
        if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'd1);
        data = resp_data;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [6];

    task automatic flush_seq(input logic d);
        logic        seen;
        logic [31:0] data;
        int          lat;
        logic        bz;
        sel = d;
        wait_ready();
        req_op = 2'b01;
        req_a  = 32'hFFFF_FFFF;
        req_b  = 32'hFFFF_FFFF;
        set_rv(d, 1'b1);
        step();
        set_rv(d, 1'b0);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_low", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (resp_valid) seen = 1'b1;
            step();
        end
        check("flush_no_resp", 64'(seen), 64'd0);
        do_op(d, 2'b00, 32'd7, 32'd9, data, lat, bz);
        check("flush_next_data", 64'(data), 64'h3F);
        check("flush_next_lat", 64'(lat), 64'(exp_lat(2'b00, d)));
        release_resp();
    endtask

    initial begin
        logic [31:0] data, sv, cor [5];
        logic [1:0]  op;
        logic [31:0] a, b;
        int          lat, n;
        logic        bz, dd;

        vt[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
        vt[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vt[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[4] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vt[5] = '{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006};
        cor = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

        // Reset state.
        step();
        step();
        check("rst_p1", {60'd0, rq0, vv0, bz0, 1'b0}, 64'd0);
        check("rst_p3", {60'd0, rq1, vv1, bz1, 1'b0}, 64'd0);
        check("rst_data", {d1, d0}, 64'd0);
        reset = 1'b0;
        step();
        check("rst_release_ready", {62'd0, rq1, rq0}, 64'd3);

        // Table vectors on both pipe depths.
        for (int di = 0; di < 2; di++) begin
            dd = di[0];
            for (int i = 0; i < 6; i++) begin
                do_op(dd, vt[i].op, vt[i].a, vt[i].b, data, lat, bz);
                check($sformatf("vec%0d_p%0d_data", i, di), 64'(data), 64'(vt[i].exp));
                check($sformatf("vec%0d_p%0d_lat", i, di), 64'(lat), 64'(exp_lat(vt[i].op, dd)));
                if (i == 0 && di == 0) check("vec0_busy", 64'(bz), 64'd1);
                release_resp();
            end
        end

        // Random ops vs. reference model.
        for (int i = 0; i < 60; i++) begin
            dd = i[0];
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? cor[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? cor[$urandom_range(0, 4)] : $urandom;
            do_op(dd, op, a, b, data, lat, bz);
            check($sformatf("rnd%0d_data op%0d a%0h b%0h", i, op, a, b), 64'(data), 64'(model(op, a, b)));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(op, dd)));
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) step();
            release_resp();
        end

        // Response stall with noisy request inputs.
        do_op(1'b0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, sv, lat, bz);
        check("stall_first", 64'(sv), 64'(model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0)));
        for (int i = 0; i < 10; i++) begin
            req_a = $urandom;
            req_b = $urandom;
            rv0   = i[0];
            step();
            check($sformatf("stall_hold%0d", i), {30'd0, resp_valid, req_ready, resp_data},
                  {30'd0, 1'b1, 1'b0, sv});
        end
        rv0 = 1'b0;
        release_resp();
        check("stall_idle", {62'd0, busy, req_ready}, 64'd1);
        do_op(1'b0, 2'b00, 32'd2, 32'd3, data, lat, bz);
        check("stall_next", 64'(data), 64'd6);
        release_resp();

        // Flush in flight, both depths.
        flush_seq(1'b0);
        flush_seq(1'b1);

        // Flush in DONE drops the response.
        do_op(1'b0, 2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, data, lat, bz);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_done", {62'd0, resp_valid, busy}, 64'd0);

        // Flush in IDLE does not block an accept.
        sel = 1'b0;
        wait_ready();
        req_op = 2'b00;
        req_a  = 32'd5;
        req_b  = 32'd6;
        rv0    = 1'b1;
        flush  = 1'b1;
        step();
        rv0   = 1'b0;
        flush = 1'b0;
        check("flush_idle_accept", 64'(busy), 64'd1);
        n = 0;
        while (!resp_valid && n < 30) begin
            step();
            n++;
        end
        check("flush_idle_data", {31'd0, resp_valid, resp_data}, {31'd0, 1'b1, 32'd30});
        release_resp();

        // Reset while in DONE.
        do_op(1'b0, 2'b11, 32'hFFFF_FFF0, 32'h0000_0010, data, lat, bz);
        check("rstdone_data", 64'(data), 64'(model(2'b11, 32'hFFFF_FFF0, 32'h10)));
        reset = 1'b1;
        step();
        check("rstdone_held0", {62'd0, resp_valid, req_ready}, 64'd0);
        step();
        check("rstdone_held1", {62'd0, resp_valid, req_ready}, 64'd0);
        reset = 1'b0;
        step();
        check("rstdone_release", 64'(req_ready), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
